// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-interface stage between the
// control unit and external memory.
package mem_pkg;

    localparam int unsigned AW_DEFAULT      = 8;
    localparam int unsigned DW_DEFAULT      = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 15;

    // Encoding of the control unit's rnw strobe
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count from 0 up to and including max_count
    function automatic int unsigned timer_width(input int unsigned max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/mem_timer.sv
// Saturating wait-state counter; expired stays high once MAX is reached
// until the next clear.
module mem_timer
    import mem_pkg::*;
#(
    parameter int unsigned MAX = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = timer_width(MAX);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CW'(MAX))) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(MAX));

endmodule

// File: rtl/mem_ctrl.sv
// Memory-interface stage: holds MAR/MBR, converts a WMFC request into a
// req/ack memory handshake, and always returns a one-cycle MFC (timeout-bounded).
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned AW      = AW_DEFAULT,
    parameter int unsigned DW      = DW_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] bus_out,
    output logic          bus_drive,
    input  logic          MAR_in,
    input  logic          MBR_in,
    input  logic          MBR_out,
    input  logic          req,
    input  logic          rnw,
    output logic          MFC,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    state_t        state, state_nxt;
    logic          dir, dir_nxt;
    logic [AW-1:0] mar, mar_nxt;
    logic [DW-1:0] mbr, mbr_nxt;
    logic          mfc_q, mfc_nxt;
    logic          err_q, err_nxt;
    logic          mem_req_q, mem_req_nxt;
    logic          mem_we_q, mem_we_nxt;
    logic          tmr_clr, tmr_en, tmr_expired;

    mem_timer #(
        .MAX (TIMEOUT)
    ) u_timer (
        .clk     (CLK),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // State and datapath registers; reset abandons any in-flight access
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state     <= IDLE;
            dir       <= WRITE;
            mar       <= '0;
            mbr       <= '0;
            mfc_q     <= 1'b0;
            err_q     <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            dir       <= dir_nxt;
            mar       <= mar_nxt;
            mbr       <= mbr_nxt;
            mfc_q     <= mfc_nxt;
            err_q     <= err_nxt;
            mem_req_q <= mem_req_nxt;
            mem_we_q  <= mem_we_nxt;
        end
    end

    // Next-state, register updates and next output values
    always_comb begin
        state_nxt   = state;
        dir_nxt     = dir;
        mar_nxt     = mar;
        mbr_nxt     = mbr;
        err_nxt     = err_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;

        case (state)
            IDLE: begin
                // MAR/MBR are only writable here so they stay frozen mid-access
                if (MAR_in) begin
                    mar_nxt = bus_in[AW-1:0];
                end
                if (MBR_in) begin
                    mbr_nxt = bus_in;
                end
                if (req) begin
                    dir_nxt   = rnw;
                    err_nxt   = 1'b0;
                    tmr_clr   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                tmr_en = 1'b1;
                // An ack on the expiry cycle still counts as success
                if (mem_ack) begin
                    if (dir == READ) begin
                        mbr_nxt = mem_rdata;
                    end
                    state_nxt = DONE;
                end else if (tmr_expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        mfc_nxt     = (state_nxt == DONE);
        mem_req_nxt = (state_nxt == WAIT);
        mem_we_nxt  = (state_nxt == WAIT) && (dir_nxt == WRITE);
    end

    assign MFC       = mfc_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mar;
    assign mem_wdata = mbr;
    assign bus_out   = mbr;
    assign bus_drive = MBR_out;

endmodule
